dmem_responder: RTL and testbench

Data-memory responder for the pipelined RISC-V core. It services the core's MEM-stage data port (address, write data, memory-write strobe) with an internal word-organised SRAM and a programmable number of wait states. While an access is outstanding it drives a stall request to the core's hazard logic, and it returns registered read data on a one-cycle response pulse. It replaces the zero-latency behavioural data memory when the pipeline's stall path is exercised.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM behind a wait-state FSM that stalls the core and returns
// registered load data on a one-cycle response pulse. Define DMEM_BSTRB_EN for byte-strobed stores.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BSTRB_EN
    input  logic [3:0]  req_be,
`endif
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        stall,
    output logic        misalign_err
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [2:0] CNT_LOAD  = ZERO_WAIT ? 3'd0 : 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_next;
    logic [2:0]      cnt, cnt_next;
    logic            accept, do_access;

    logic            lat_we;
    logic [AW-1:0]   lat_idx;
    logic [1:0]      lat_off;
    logic [31:0]     lat_wdata;
    logic [3:0]      lat_be;

    logic            acc_we;
    logic [AW-1:0]   acc_idx;
    logic [1:0]      acc_off;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic            acc_misalign;
    logic            misalign_q;
    logic [3:0]      be_in;

    logic [31:0]     mem [DEPTH_WORDS];

    // Address bits above the array index are ignored so addresses wrap modulo the array.
    logic            unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

`ifdef DMEM_BSTRB_EN
    assign be_in = req_be;
`else
    assign be_in = 4'hF;
`endif

    // Zero wait states access straight off the request; otherwise the latched copy is used.
    assign acc_we    = ZERO_WAIT ? req_we              : lat_we;
    assign acc_idx   = ZERO_WAIT ? req_addr[AW+1:2]    : lat_idx;
    assign acc_off   = ZERO_WAIT ? req_addr[1:0]       : lat_off;
    assign acc_wdata = ZERO_WAIT ? req_wdata           : lat_wdata;
    assign acc_be    = ZERO_WAIT ? be_in               : lat_be;

`ifdef DMEM_BSTRB_EN
    logic [7:0] be_span;
    assign be_span      = {4'b0000, acc_be} << acc_off;
    assign acc_misalign = |be_span[7:4];
`else
    assign acc_misalign = (acc_off != 2'b00);
`endif

    // With no wait states the core never stalls, so a request seen in RESP is a new one.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (ZERO_WAIT) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = CNT_LOAD;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == 3'd0) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            RESP: begin
                if (ZERO_WAIT && req_valid) begin
                    accept     = 1'b1;
                    do_access  = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            rsp_rdata  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (do_access) begin
                misalign_q <= acc_misalign;
                if (!acc_we) begin
                    rsp_rdata <= mem[acc_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_idx   <= req_addr[AW+1:2];
            lat_off   <= req_addr[1:0];
            lat_wdata <= req_wdata;
            lat_be    <= be_in;
        end
    end

    // A reset on the completion edge cancels the pending store.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid    = (state == RESP);
    assign misalign_err = (state == RESP) && misalign_q;
    assign stall        = !rst && req_valid &&
                          ((state == IDLE && !ZERO_WAIT) || state == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven by directed and random accesses
// against an array model, and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;
    localparam int WAIT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid, a_we, a_rsp_valid, a_stall, a_mis;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_we, b_rsp_valid, b_stall, b_mis;
    logic [31:0] b_addr, b_wdata, b_rdata;
`ifdef DMEM_BSTRB_EN
    logic [3:0]  a_be, b_be;
`endif

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [1024];
    logic [31:0] model_last = 32'd0;
    logic [31:0] obs;
    logic [31:0] pre [4];

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
        .req_wdata(a_wdata),
`ifdef DMEM_BSTRB_EN
        .req_be(a_be),
`endif
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .stall(a_stall), .misalign_err(a_mis)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
        .req_wdata(b_wdata),
`ifdef DMEM_BSTRB_EN
        .req_be(b_be),
`endif
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .stall(b_stall), .misalign_err(b_mis)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Behaves like the core: holds the request while stalled, drops it after a non-stalled cycle.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, output int stall_cyc, output int rsp_cnt,
                                 output int latency, output int stray, output logic [31:0] rdata,
                                 output logic mis);
        logic drop;
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
`ifdef DMEM_BSTRB_EN
        a_be = be;
`endif
        stall_cyc = 0; rsp_cnt = 0; latency = -1; stray = 0; rdata = '0; mis = 1'b0;
        for (int c = 0; c < WAIT + 5; c++) begin
            @(negedge clk);
            if (a_stall) stall_cyc++;
            if (a_rsp_valid) begin
                rsp_cnt++;
                if (latency < 0) begin
                    latency = c; rdata = a_rdata; mis = a_mis;
                end
            end else if (a_mis) begin
                stray++;
            end
            drop = a_valid && !a_stall;
            @(posedge clk); #1;
            if (drop) a_valid = 1'b0;
        end
        a_valid = 1'b0;
    endtask

    task automatic runA(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] obs_rdata);
        int sc, rc, lat, stray, idx;
        logic [31:0] rd, exp_rd;
        logic mis, exp_mis;
        idx = int'((addr >> 2) % 32'd1024);
`ifdef DMEM_BSTRB_EN
        begin
            int top = -1;
            for (int i = 0; i < 4; i++) if (be[i]) top = i;
            exp_mis = (top >= 0) && (int'(addr % 32'd4) + top >= 4);
        end
`else
        exp_mis = (addr % 32'd4) != 0;
`endif
        exp_rd = we ? model_last : model_mem[idx];
        applyStimulus(we, addr, wdata, be, sc, rc, lat, stray, rd, mis);
        checkOutput({tag, "_stall_cycles"}, sc, WAIT + 1);
        checkOutput({tag, "_rsp_count"}, rc, 1);
        checkOutput({tag, "_latency"}, lat, WAIT + 1);
        checkOutput({tag, "_rdata"}, rd, exp_rd);
        checkOutput({tag, "_misalign"}, mis, exp_mis);
        checkOutput({tag, "_stray_misalign"}, stray, 0);
        if (we) begin
            for (int i = 0; i < 4; i++) if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
        end else begin
            model_last = model_mem[idx];
        end
        obs_rdata = rd;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_wdata = 32'h0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h10; b_wdata = 32'h0;
`ifdef DMEM_BSTRB_EN
        a_be = 4'hF; b_be = 4'hF;
`endif
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_a_stall", a_stall, 1'b0);
            checkOutput("rst_a_rsp", a_rsp_valid, 1'b0);
            checkOutput("rst_a_rdata", a_rdata, 32'd0);
            checkOutput("rst_a_mis", a_mis, 1'b0);
            checkOutput("rst_b_stall", b_stall, 1'b0);
            checkOutput("rst_b_rsp", b_rsp_valid, 1'b0);
            checkOutput("rst_b_rdata", b_rdata, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

        runA("st_deadbeef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, obs);
        runA("ld_deadbeef", 1'b0, 32'h10, 32'h0, 4'hF, obs);
        checkOutput("ld_deadbeef_const", obs, 32'hDEADBEEF);

        runA("st_wrap", 1'b1, 32'h1004, 32'h1234, 4'hF, obs);
        runA("ld_wrap", 1'b0, 32'h4, 32'h0, 4'hF, obs);
        checkOutput("ld_wrap_const", obs, 32'h1234);
        runA("ld_misaligned", 1'b0, 32'h6, 32'h0, 4'hF, obs);
        checkOutput("ld_misaligned_const", obs, 32'h1234);
        checkOutput("ld_misaligned_flag", dut_a_mis_seen(), 1'b0);

        // Reset lands on the edge where the store would complete.
        runA("st_prior", 1'b1, 32'h20, 32'h0BADF00D, 4'hF, obs);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("midrst_busy_stall", a_stall, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; a_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rsp", a_rsp_valid, 1'b0);
        checkOutput("midrst_rdata", a_rdata, 32'd0);
        checkOutput("midrst_mis", a_mis, 1'b0);
        @(posedge clk); #1;
        model_last = 32'd0;
        runA("ld_after_rst", 1'b0, 32'h20, 32'h0, 4'hF, obs);
        checkOutput("ld_after_rst_const", obs, 32'h0BADF00D);

`ifdef DMEM_BSTRB_EN
        runA("st_be_full", 1'b1, 32'h0, 32'h11223344, 4'hF, obs);
        runA("st_be_lane1", 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0010, obs);
        runA("ld_be", 1'b0, 32'h0, 32'h0, 4'hF, obs);
        checkOutput("ld_be_const", obs, 32'h1122FF44);
`endif

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ad = ($urandom & 32'hFFFF_F000) | (i << 2);
            runA("rnd_init", 1'b1, ad, $urandom, 4'hF, obs);
        end
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ad = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2)
                              | $urandom_range(0, 3);
            runA("rnd_op", 1'($urandom_range(0, 1)), ad, $urandom, 4'hF, obs);
        end

        for (int i = 0; i < 4; i++) pre[i] = $urandom;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                b_valid = 1'b1; b_we = (c < 4); b_addr = (c % 4) * 4; b_wdata = pre[c % 4];
            end else begin
                b_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput("w0_stall", b_stall, 1'b0);
            checkOutput("w0_rsp", b_rsp_valid, (c > 0 && c < 9));
            checkOutput("w0_rdata", b_rdata, (c >= 5 && c < 9) ? pre[c - 5] : (c >= 9 ? pre[3] : 32'd0));
            checkOutput("w0_mis", b_mis, 1'b0);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Misalign must have dropped once the response pulse is over.
    function automatic logic dut_a_mis_seen();
        return a_mis;
    endfunction

endmodule
